// File: rtl/fft_stream_checker.sv
// fft_stream_checker
//   Compares the streamed output of an FFT core against a reference stream
//   that is presented LATENCY cycles ahead of the matching DUT word. Each
//   word carries NLANES complex samples; a frame is WPF = N/NLANES words.
//   A run checks num_frames frames and reports per-frame and per-run results.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           arms a run (accepted only when idle)
//   num_frames      frames per run, sampled on start
//   tol             unsigned per-component tolerance, sampled on start
//   exp_valid       reference word present this cycle
//   exp_data        reference word, lane k = {re, im} at [(k+1)*2*NBITS_OUT-1 : k*2*NBITS_OUT]
//   dut_data        FFT output word, same packing, LATENCY cycles behind exp_data
//   busy            run in progress
//   done            one-cycle end-of-run pulse
//   pass            run result, valid from done until the next start
//   frame_done      one-cycle pulse per checked frame
//   frame_ok        frame result, qualified by frame_done
//   err_count       mismatching words, saturating at 0xFFFF
//   lane_err        sticky per-lane mismatch flags
//   first_err_frame frame index of the first mismatch of the run
//   first_err_word  word index of the first mismatch of the run
module fft_stream_checker #(
    parameter int NBITS_OUT = 15,
    parameter int NLANES    = 4,
    parameter int N         = 128,
    parameter int LATENCY   = 17,
    localparam int WPF      = N / NLANES,
    localparam int WW       = (WPF > 1) ? $clog2(WPF) : 1,
    localparam int DW       = NLANES * 2 * NBITS_OUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          num_frames,
    input  logic [NBITS_OUT-1:0] tol,
    input  logic                 exp_valid,
    input  logic [DW-1:0]        exp_data,
    input  logic [DW-1:0]        dut_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [15:0]          err_count,
    output logic [NLANES-1:0]    lane_err,
    output logic [15:0]          first_err_frame,
    output logic [WW-1:0]        first_err_word
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;

    logic [LATENCY-1:0]    dly_vld_r;
    logic [DW-1:0]         dly_data_r [LATENCY];

    logic [15:0]           num_frames_r;
    logic [NBITS_OUT-1:0]  tol_r;
    logic [WW-1:0]         word_cnt_r;
    logic [15:0]           frame_cnt_r;
    logic                  frame_err_r;

    logic                  start_ok_s;
    logic                  cmp_vld_s;
    logic [NLANES-1:0]     lane_mis_s;
    logic                  word_mis_s;
    logic                  last_word_s;
    logic                  last_frame_s;
    logic [15:0]           err_next_s;

    // |dut - exp| > tol for one component; the difference is one bit wider
    // than the samples so full-scale opposite-sign values cannot overflow.
    function automatic logic comp_mismatch(
        input logic [NBITS_OUT-1:0] dut_c,
        input logic [NBITS_OUT-1:0] exp_c,
        input logic [NBITS_OUT-1:0] tol_c
    );
        logic [NBITS_OUT:0] diff;
        logic [NBITS_OUT:0] mag;
        diff = {dut_c[NBITS_OUT-1], dut_c} - {exp_c[NBITS_OUT-1], exp_c};
        if (diff[NBITS_OUT]) begin
            mag = ~diff + {{NBITS_OUT{1'b0}}, 1'b1};
        end else begin
            mag = diff;
        end
        return mag > {1'b0, tol_c};
    endfunction

    assign start_ok_s   = start && (state_r == S_IDLE);
    assign cmp_vld_s    = (state_r == S_RUN) && dly_vld_r[LATENCY-1];
    assign word_mis_s   = |lane_mis_s;
    assign last_word_s  = cmp_vld_s && (word_cnt_r == WW'(WPF - 1));
    assign last_frame_s = (frame_cnt_r == (num_frames_r - 16'd1));
    assign err_next_s   = (word_mis_s && (err_count != 16'hFFFF)) ? (err_count + 16'd1) : err_count;

    // Per-lane comparison of the delayed reference word against the DUT word
    always_comb begin
        lane_mis_s = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (cmp_vld_s) begin
                lane_mis_s[k] =
                    comp_mismatch(dut_data[k*2*NBITS_OUT + NBITS_OUT +: NBITS_OUT],
                                  dly_data_r[LATENCY-1][k*2*NBITS_OUT + NBITS_OUT +: NBITS_OUT], tol_r) ||
                    comp_mismatch(dut_data[k*2*NBITS_OUT +: NBITS_OUT],
                                  dly_data_r[LATENCY-1][k*2*NBITS_OUT +: NBITS_OUT], tol_r);
            end else begin
                lane_mis_s[k] = 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = (num_frames == 16'd0) ? S_DONE : S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_word_s && last_frame_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Reference delay line; valid bits are dropped whenever the next state
    // is not RUN, which flushes words still in flight when the run ends
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dly_data_r[i] <= '0;
            end
        end else if (start_ok_s || (state_s != S_RUN)) begin
            dly_vld_r <= '0;
        end else begin
            dly_vld_r[0]  <= exp_valid;
            dly_data_r[0] <= exp_data;
            for (int i = 1; i < LATENCY; i++) begin
                dly_vld_r[i]  <= dly_vld_r[i-1];
                dly_data_r[i] <= dly_data_r[i-1];
            end
        end
    end

    // Counters, error bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            frame_done      <= 1'b0;
            frame_ok        <= 1'b0;
            err_count       <= '0;
            lane_err        <= '0;
            first_err_frame <= '0;
            first_err_word  <= '0;
            num_frames_r    <= '0;
            tol_r           <= '0;
            word_cnt_r      <= '0;
            frame_cnt_r     <= '0;
            frame_err_r     <= 1'b0;
        end else begin
            busy       <= (state_s == S_RUN);
            done       <= (state_s == S_DONE);
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            if (start_ok_s) begin
                err_count       <= '0;
                lane_err        <= '0;
                first_err_frame <= '0;
                first_err_word  <= '0;
                word_cnt_r      <= '0;
                frame_cnt_r     <= '0;
                frame_err_r     <= 1'b0;
                num_frames_r    <= num_frames;
                tol_r           <= tol;
                // An empty run finishes immediately and cannot fail
                pass            <= (num_frames == 16'd0);
            end else if (cmp_vld_s) begin
                err_count <= err_next_s;
                lane_err  <= lane_err | lane_mis_s;
                // err_count only grows within a run, so zero marks "no error yet"
                if (word_mis_s && (err_count == 16'd0)) begin
                    first_err_frame <= frame_cnt_r;
                    first_err_word  <= word_cnt_r;
                end
                if (last_word_s) begin
                    word_cnt_r  <= '0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                    frame_done  <= 1'b1;
                    frame_ok    <= !(frame_err_r || word_mis_s);
                    frame_err_r <= 1'b0;
                end else begin
                    word_cnt_r  <= word_cnt_r + WW'(1);
                    frame_err_r <= frame_err_r || word_mis_s;
                end
                if (state_s == S_DONE) begin
                    pass <= (err_next_s == 16'd0);
                end
            end
        end
    end

endmodule

// File: doc/fft_stream_checker.md
FFT_STREAM_CHECKER -- requirements
Module: fft_stream_checker

Interface
REQ-001 SHALL have parameter NBITS_OUT, default 15, meaning the width of each real/imag output component.
REQ-002 SHALL have parameter NLANES, default 4, meaning the number of parallel complex lanes per word.
REQ-003 SHALL have parameter N, default 128, meaning the FFT size; words per frame WPF = N/NLANES.
REQ-004 SHALL have parameter LATENCY, default 17, meaning the cycles from exp_valid to the matching DUT word; minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: pulse that arms a run.
REQ-008 SHALL have port num_frames, input, 16 bits: frames per run, sampled on start.
REQ-009 SHALL have port tol, input, NBITS_OUT bits, unsigned: per-component tolerance, sampled on start; 0 means exact match.
REQ-010 SHALL have port exp_valid, input, 1 bit: expected word present.
REQ-011 SHALL have port exp_data, input, NLANES*2*NBITS_OUT bits: expected word; lane k at bits [(k+1)*2*NBITS_OUT-1 : k*2*NBITS_OUT], {re,im} order, re upper.
REQ-012 SHALL have port dut_data, input, same width and packing as exp_data: FFT output word.
REQ-013 SHALL have port busy, output, 1 bit: run in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.
REQ-015 SHALL have port pass, output, 1 bit: run result, valid from done until the next start.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse per checked frame.
REQ-017 SHALL have port frame_ok, output, 1 bit: frame result, qualified by frame_done.
REQ-018 SHALL have port err_count, output, 16 bits: mismatching words, saturating.
REQ-019 SHALL have port lane_err, output, NLANES bits: sticky per-lane mismatch flags.
REQ-020 SHALL have ports first_err_frame (16 bits) and first_err_word ($clog2(WPF) bits), output: location of the first mismatch.

Function
REQ-021 SHALL implement the FSM IDLE->RUN on start; RUN->DONE after the compare of word WPF-1 of frame num_frames-1; DONE->IDLE unconditionally after one cycle.
REQ-022 SHALL, on start in IDLE, clear err_count, lane_err, first_err_* and the word/frame counters, flush the delay line, and set pass=0.
REQ-023 SHALL ignore start while in RUN or DONE.
REQ-024 SHALL, on start with num_frames=0, go directly to DONE and assert done with pass=1 on the next cycle.
REQ-025 SHALL delay exp_valid and exp_data through a LATENCY-stage shift register, loaded only in RUN; in IDLE, stage-0 valid is forced to 0.
REQ-026 SHALL compare the delayed expected word against dut_data in the same cycle, only when the delayed valid is 1.
REQ-027 SHALL compute each component difference signed at NBITS_OUT+1 bits; a lane mismatches when |diff_re| > tol or |diff_im| > tol.
REQ-028 SHALL register all results, so an exp_valid at cycle t updates outputs visible at cycle t+LATENCY+1.
REQ-029 SHALL count a word with any mismatching lane as one error; err_count SHALL saturate at 0xFFFF.
REQ-030 SHALL set lane_err[k] on a lane-k mismatch and hold it until the next start or rst.
REQ-031 SHALL capture first_err_frame and first_err_word only on the first mismatch of a run.
REQ-032 SHALL wrap the word counter from WPF-1 to 0 and increment the frame counter on wrap.
REQ-033 SHALL pulse frame_done on wrap, with frame_ok=1 when that frame had no mismatch.
REQ-034 SHALL assert done for one cycle in DONE, with pass=1 when err_count==0.
REQ-035 SHALL drive busy=1 exactly in RUN.
REQ-036 SHALL discard any delayed words still in flight at the DONE transition, without comparing them.
REQ-037 SHALL count no gap cycles: cycles with delayed valid=0 neither advance counters nor flag errors.

Reset
REQ-038 SHALL, on rst, return to IDLE and zero every output, the delay line and all counters, taking priority over start and in-flight data.
REQ-039 SHALL, on rst mid-run, abort the run with no done pulse.

Verification
REQ-040 SHALL cover exact match: tol=0, num_frames=2, 64 words with dut_data equal to exp_data delayed 17 cycles -> two frame_done pulses with frame_ok=1, done with pass=1, err_count=0.
REQ-041 SHALL cover a single error: frame 1, word 5, lane 2 re off by 1, tol=0 -> err_count=1, lane_err=4'b0100, first_err_frame=1, first_err_word=5, pass=0.
REQ-042 SHALL cover tolerance: tol=2 with all components off by +/-2 -> pass=1; a single component off by 3 -> err_count=1.
REQ-043 SHALL cover saturation: 70000 words all mismatching -> err_count=0xFFFF, not wrapped.
REQ-044 SHALL cover gaps and zero frames: exp_valid toggling 1/0 -> same results as contiguous input; num_frames=0 -> done one cycle after start with pass=1.
REQ-045 SHALL cover reset mid-run: rst asserted at word 10 -> next cycle busy=0, all outputs 0, no done pulse; a subsequent run behaves normally.
